// File: rtl/finger_count_tally.sv
// Stability filter and saturating tally for finger-count decoder results.
// Optional FC_TALLY_MAXHOLD_EN adds max_value, the largest count committed since rst/clr.
module finger_count_tally #(
    parameter int unsigned STABLE_N = 3,
    parameter int unsigned TOT_W    = 12,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [3:0]       in_result,
    output logic             commit,
    output logic [3:0]       commit_value,
    output logic [TOT_W-1:0] total,
    output logic             total_sat,
    output logic [ERR_W-1:0] err_cnt,
`ifdef FC_TALLY_MAXHOLD_EN
    output logic [3:0]       max_value,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StTrack, StHold} state_e;

    localparam logic [3:0]  StableN = 4'(STABLE_N);
    localparam int unsigned SumW    = TOT_W + 1;

    state_e          state_q, state_d;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      run_q, run_d;
    logic            legal, error, do_commit;
    logic [SumW-1:0] sum;

    always_comb begin
        legal     = in_valid && (in_result >= 4'd1) && (in_result <= 4'd10);
        error     = in_valid && !legal;
        state_d   = state_q;
        cand_d    = cand_q;
        run_d     = run_q;
        do_commit = 1'b0;
        if (error) begin
            state_d = StIdle;
            run_d   = '0;
        end else if (legal) begin
            case (state_q)
                StIdle: begin
                    cand_d = in_result;
                    run_d  = 4'd1;
                    if (StableN == 4'd1) begin
                        do_commit = 1'b1;
                        state_d   = StHold;
                    end else begin
                        state_d = StTrack;
                    end
                end
                StTrack: begin
                    if (in_result == cand_q) begin
                        run_d = run_q + 4'd1;
                        if (run_d == StableN) begin
                            do_commit = 1'b1;
                            state_d   = StHold;
                        end
                    end else begin
                        cand_d = in_result;
                        run_d  = 4'd1;
                    end
                end
                StHold: begin
                    // A held value never recommits; only a change starts a new run.
                    if (in_result != cand_q) begin
                        cand_d = in_result;
                        run_d  = 4'd1;
                        if (StableN == 4'd1) begin
                            do_commit = 1'b1;
                        end else begin
                            state_d = StTrack;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        sum = {1'b0, total} + SumW'(cand_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cand_q       <= '0;
            run_q        <= '0;
            commit       <= 1'b0;
            commit_value <= '0;
            total        <= '0;
            total_sat    <= 1'b0;
            err_cnt      <= '0;
            busy         <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            run_q   <= run_d;
            commit  <= do_commit;
            busy    <= (state_d != StIdle);
            if (do_commit) begin
                commit_value <= cand_d;
            end
            if (clr) begin
                total     <= '0;
                total_sat <= 1'b0;
            end else if (do_commit) begin
                if (sum[TOT_W]) begin
                    total     <= '1;
                    total_sat <= 1'b1;
                end else begin
                    total <= sum[TOT_W-1:0];
                end
            end
            if (clr) begin
                err_cnt <= '0;
            end else if (error && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

`ifdef FC_TALLY_MAXHOLD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            max_value <= '0;
        end else if (clr) begin
            max_value <= do_commit ? cand_d : 4'd0;
        end else if (do_commit && (cand_d > max_value)) begin
            max_value <= cand_d;
        end
    end
`endif

endmodule

// File: tb/tb_finger_count_tally.sv
// Bench for finger_count_tally: default instance plus a narrow TOT_W=4/ERR_W=2 instance.
module tb_finger_count_tally;

    logic        clk = 1'b0;
    logic        rst, clr, in_valid;
    logic [3:0]  in_result;

    logic        commit_a, commit_b;
    logic [3:0]  cv_a, cv_b;
    logic [11:0] total_a;
    logic [3:0]  total_b;
    logic        sat_a, sat_b;
    logic [7:0]  err_a;
    logic [1:0]  err_b;
    logic        busy_a, busy_b;
`ifdef FC_TALLY_MAXHOLD_EN
    logic [3:0]  max_a, max_b;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    finger_count_tally dut_a (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_result    (in_result),
        .commit       (commit_a),
        .commit_value (cv_a),
        .total        (total_a),
        .total_sat    (sat_a),
        .err_cnt      (err_a),
`ifdef FC_TALLY_MAXHOLD_EN
        .max_value    (max_a),
`endif
        .busy         (busy_a)
    );

    finger_count_tally #(.STABLE_N(3), .TOT_W(4), .ERR_W(2)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_result    (in_result),
        .commit       (commit_b),
        .commit_value (cv_b),
        .total        (total_b),
        .total_sat    (sat_b),
        .err_cnt      (err_b),
`ifdef FC_TALLY_MAXHOLD_EN
        .max_value    (max_b),
`endif
        .busy         (busy_b)
    );

    typedef struct {
        logic       rst, clr, vld;
        logic [3:0] res;
        logic       c;
        logic [3:0] cv;
        int         t12, t4;
        logic       s4;
        int         e;
        logic       b;
        logic [3:0] mx;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic v(input logic r, input logic cl, input logic vl, input logic [3:0] rs,
                     input logic c, input logic [3:0] cv, input int t12, input int t4,
                     input logic s4, input int e, input logic b, input logic [3:0] mx);
        vec_t x;
        x.rst = r; x.clr = cl; x.vld = vl; x.res = rs;
        x.c = c; x.cv = cv; x.t12 = t12; x.t4 = t4; x.s4 = s4; x.e = e; x.b = b; x.mx = mx;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int step, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
        end
    endtask

    task automatic compare(input int step, input vec_t x);
        chk("commit_a", step, int'(commit_a), int'(x.c));
        chk("commit_b", step, int'(commit_b), int'(x.c));
        chk("commit_value_a", step, int'(cv_a), int'(x.cv));
        chk("commit_value_b", step, int'(cv_b), int'(x.cv));
        chk("total_a", step, int'(total_a), x.t12);
        chk("total_b", step, int'(total_b), x.t4);
        chk("total_sat_a", step, int'(sat_a), 0);
        chk("total_sat_b", step, int'(sat_b), int'(x.s4));
        chk("err_cnt_a", step, int'(err_a), x.e);
        chk("err_cnt_b", step, int'(err_b), x.e);
        chk("busy_a", step, int'(busy_a), int'(x.b));
        chk("busy_b", step, int'(busy_b), int'(x.b));
`ifdef FC_TALLY_MAXHOLD_EN
        chk("max_value_a", step, int'(max_a), int'(x.mx));
        chk("max_value_b", step, int'(max_b), int'(x.mx));
`endif
    endtask

    task automatic drive(input logic r, input logic cl, input logic vl, input logic [3:0] rs);
        rst = r; clr = cl; in_valid = vl; in_result = rs;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 4'd0);

        // rst clr vld res | commit cv tot12 tot4 sat4 err busy max
        v(1,0,0,0,   0,0,0,0,0,0,0,0);
        // 5,5,5 commits once; further 5s held; then 7,7,7
        v(0,0,1,5,   0,0,0,0,0,0,1,0);
        v(0,0,1,5,   0,0,0,0,0,0,1,0);
        v(0,0,1,5,   1,5,5,5,0,0,1,5);
        v(0,0,1,5,   0,5,5,5,0,0,1,5);
        v(0,0,1,5,   0,5,5,5,0,0,1,5);
        v(0,0,1,5,   0,5,5,5,0,0,1,5);
        v(0,0,1,7,   0,5,5,5,0,0,1,5);
        v(0,0,1,7,   0,5,5,5,0,0,1,5);
        v(0,0,1,7,   1,7,12,12,0,0,1,7);
        v(0,1,0,0,   0,7,0,0,0,0,1,0);
        // 3,3,0 breaks the run; 3,3,3 then commits
        v(0,0,1,3,   0,7,0,0,0,0,1,0);
        v(0,0,1,3,   0,7,0,0,0,0,1,0);
        v(0,0,1,0,   0,7,0,0,0,1,0,0);
        v(0,0,1,3,   0,7,0,0,0,1,1,0);
        v(0,0,1,3,   0,7,0,0,0,1,1,0);
        v(0,0,1,3,   1,3,3,3,0,1,1,3);
        // same with illegal 12 as the error
        v(0,0,1,3,   0,3,3,3,0,1,1,3);
        v(0,0,1,3,   0,3,3,3,0,1,1,3);
        v(0,0,1,12,  0,3,3,3,0,2,0,3);
        v(0,0,1,3,   0,3,3,3,0,2,1,3);
        v(0,0,1,3,   0,3,3,3,0,2,1,3);
        v(0,0,1,3,   1,3,6,6,0,2,1,3);
        // gaps inside a run; then 6,4 from HOLD restarts tracking on 4
        v(0,0,1,4,   0,3,6,6,0,2,1,3);
        v(0,0,0,9,   0,3,6,6,0,2,1,3);
        v(0,0,0,9,   0,3,6,6,0,2,1,3);
        v(0,0,1,4,   0,3,6,6,0,2,1,3);
        v(0,0,1,4,   1,4,10,10,0,2,1,4);
        v(0,0,1,6,   0,4,10,10,0,2,1,4);
        v(0,0,1,4,   0,4,10,10,0,2,1,4);
        v(0,0,1,4,   0,4,10,10,0,2,1,4);
        v(0,0,1,4,   1,4,14,14,0,2,1,4);
        // saturation on the narrow instance, then clr with a commit
        v(0,1,0,0,   0,4,0,0,0,0,1,0);
        v(0,0,1,10,  0,4,0,0,0,0,1,0);
        v(0,0,1,10,  0,4,0,0,0,0,1,0);
        v(0,0,1,10,  1,10,10,10,0,0,1,10);
        v(0,0,1,9,   0,10,10,10,0,0,1,10);
        v(0,0,1,9,   0,10,10,10,0,0,1,10);
        v(0,0,1,9,   1,9,19,15,1,0,1,10);
        v(0,0,1,2,   0,9,19,15,1,0,1,10);
        v(0,0,1,2,   0,9,19,15,1,0,1,10);
        v(0,1,1,2,   1,2,0,0,0,0,1,2);
        // clr with an error: counter cleared, FSM still idles
        v(0,1,1,0,   0,2,0,0,0,0,0,0);
        v(0,0,1,0,   0,2,0,0,0,1,0,0);
        // rst mid-run discards the partial run
        v(0,0,1,2,   0,2,0,0,0,1,1,0);
        v(0,0,1,2,   0,2,0,0,0,1,1,0);
        v(1,0,1,2,   0,0,0,0,0,0,0,0);
        v(0,0,1,2,   0,0,0,0,0,0,1,0);
        v(0,0,1,2,   0,0,0,0,0,0,1,0);
        v(0,0,1,2,   1,2,2,2,0,0,1,2);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].clr, vecs[i].vld, vecs[i].res);
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            compare(i, exp_q.pop_front());
        end

        // Error counter saturation: 300 bad codewords of mixed kinds
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b0, 1'b1, (i % 3 == 0) ? 4'd0 : ((i % 3 == 1) ? 4'd11 : 4'd15));
            @(posedge clk);
            #1;
            if (i == 4) begin
                chk("err_cnt_a_five", i, int'(err_a), 5);
                chk("err_cnt_b_sat", i, int'(err_b), 3);
            end
        end
        chk("err_cnt_a_sat", 300, int'(err_a), 255);
        chk("err_cnt_b_sat", 300, int'(err_b), 3);
        chk("busy_after_err", 300, int'(busy_a), 0);
        chk("commit_after_err", 300, int'(commit_a), 0);
        chk("total_kept", 300, int'(total_a), 2);

        // Commit pulse lasts exactly one cycle
        drive(1'b0, 1'b0, 1'b1, 4'd8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("commit_pulse_on", 0, int'(commit_a), 1);
        chk("commit_value_8", 0, int'(cv_a), 8);
        chk("total_10", 0, int'(total_a), 10);
        @(posedge clk); #1;
        chk("commit_pulse_off", 1, int'(commit_a), 0);
        chk("commit_value_held", 1, int'(cv_a), 8);
        chk("total_held", 1, int'(total_a), 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/finger_count_tally.md
Name: finger_count_tally

Overview:
- Downstream consumer of the 9-bit finger-count decoder's 4-bit result:
  - 1..10 = legal count.
  - 0 = decode error.
  - 11..15 = illegal, treated as error.
- Filters the sampled result stream for stability, commits each stable count once, and accumulates committed counts into a saturating total.
- Keeps a saturating error counter for bad codewords.
- Output feeds the status/display logic.

Parameters:
- STABLE_N, 3, consecutive identical legal valid samples required to commit (legal range 1..15).
- TOT_W, 12, width of the running total.
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- clr  input  1  synchronous clear of total, total_sat and err_cnt; FSM unaffected.
- in_valid  input  1  in_result is a sample this cycle.
- in_result  input  4  decoder result (0, 1..10, 11..15).
- commit  output  1  one-cycle pulse: a count was committed.
- commit_value  output  4  last committed count, held between commits.
- total  output  TOT_W  saturating sum of committed counts.
- total_sat  output  1  sticky: total has saturated.
- err_cnt  output  ERR_W  saturating count of error samples.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is synchronous and active-high.
  - All outputs are registered.
- Reset values:
  - commit=0, commit_value=0, total=0, total_sat=0, err_cnt=0, busy=0.
  - FSM=IDLE, cand=0, run=0.
- Internal state: cand (4b), run (4b), FSM IDLE/TRACK/HOLD.
- Terms:
  - Legal = in_valid & in_result in 1..10.
  - Error = in_valid & in_result in {0, 11..15}.
- in_valid=0: FSM, cand and run hold; gaps never break a run.
- Error in any state:
  - err_cnt += 1, saturating at all-ones.
  - FSM -> IDLE, run=0.
  - No commit.
- IDLE, legal v:
  - cand=v, run=1.
  - If STABLE_N==1: commit v, -> HOLD.
  - Else -> TRACK.
- TRACK, legal v:
  - v==cand: run+=1. If run reaches STABLE_N: commit, -> HOLD.
  - v!=cand: cand=v, run=1, stay TRACK.
- HOLD, legal v:
  - v==cand: no action. A held value never recommits.
  - v!=cand: cand=v, run=1, -> TRACK.
  - Exception when STABLE_N==1: commit v immediately and stay in HOLD.
- Commit action, on the edge after the completing sample:
  - commit=1 for exactly one cycle.
  - commit_value=cand.
  - total=total+cand. If the sum exceeds 2^TOT_W-1: total=2^TOT_W-1, total_sat=1.
- Latency: commit pulse is visible 1 cycle after the STABLE_N-th identical sample is presented.
- clr:
  - Same cycle as a commit: commit pulse and commit_value update proceed; total=0 (the add is discarded); total_sat=0.
  - Same cycle as an error: err_cnt=0; the FSM still returns to IDLE.
- rst mid-run: all state to reset values. A partial run is discarded and a new run starts from run=0.
- busy = (FSM != IDLE), registered with the FSM.

Optional Feature:
- Macro: FC_TALLY_MAXHOLD_EN.
- Defined:
  - Adds output max_value (4b, reset 0): the largest count committed since rst/clr.
  - Updated in the same cycle as commit when commit_value > max_value.
  - clr zeroes it; clr+commit in the same cycle leaves max_value = the committed value.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- STABLE_N=3; valid samples 5,5,5 -> commit high 1 cycle after the 3rd sample, commit_value=5, total=5, busy=1 (HOLD).
- Six valid 5s then 7,7,7 -> exactly one commit for 5, then one for 7; total=12; no commit for repeated 5s.
- 3,3,0 then 3,3,3 -> err_cnt=1 after the 0, busy=0 after the 0, no commit; then commit 3, total=3. Repeat with 12 instead of 0 -> err_cnt=2.
- 4, in_valid=0 for 2 cycles, 4, 4 -> commit 4 (gaps tolerated). Then 6, 4 while in HOLD -> no commit, FSM TRACK with cand=4, run=1.
- TOT_W=4: commit 10 then commit 9 -> total=15, total_sat=1. Assert clr in the same cycle as the next commit of 2 -> total=0, total_sat=0, commit pulse seen, commit_value=2.
- After 2,2 (TRACK, run=2) assert rst 1 cycle -> all outputs 0. Then 2,2 -> no commit; 3rd 2 -> commit.
